// File: rtl/store_buffer.sv
// Write-posting store buffer between the CPU data port and data memory; loads win the port, stores drain in idle cycles.
// Define STORE_BUFFER_FWD_EN to serve loads from the youngest matching buffered store instead of stalling on the hazard.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            cpu_a,
   input  logic                   cpu_we,
   input  logic                   cpu_re,
   input  logic [31:0]            cpu_wd,
   output logic [31:0]            cpu_rd,
   output logic                   stall,
   output logic [31:0]            mem_a,
   output logic                   mem_we,
   output logic [31:0]            mem_wd,
   input  logic [31:0]            mem_rd,
   input  logic                   mem_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;

   logic          full;
   logic          hit;
   logic [PW-1:0] idx;
   logic          hazard;
   logic          load_ok;
   logic          load_phase;
   logic          drain;
   logic          push;
   logic          pop;

   // Handshake: cpu_we/cpu_re are held by the CPU while stall=1 and are accepted on the first
   // edge with stall=0; mem_ready=1 completes whatever access mem_a/mem_we present at that edge.

   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign empty = (count_q == '0);

`ifdef STORE_BUFFER_FWD_EN
   logic [31:0] hit_data;
`endif

   // Scan oldest to youngest so the last match seen is the youngest entry.
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef STORE_BUFFER_FWD_EN
      hit_data = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == cpu_a[31:2])) begin
            hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
            hit_data = data_q[idx];
`endif
         end
      end
   end

`ifdef STORE_BUFFER_FWD_EN
   assign hazard  = 1'b0;
   assign load_ok = hit || mem_ready;
   assign cpu_rd  = cpu_re ? (hit ? hit_data : mem_rd) : 32'd0;
`else
   // A matching buffered store must reach memory before the load may read it.
   assign hazard  = cpu_re && hit;
   assign load_ok = !hazard && mem_ready;
   assign cpu_rd  = cpu_re ? mem_rd : 32'd0;
`endif

   assign load_phase = cpu_re && !hazard;
   assign drain      = !load_phase && !empty;
   assign pop        = drain && mem_ready;
   assign stall      = (cpu_we && full && !pop) || (cpu_re && !load_ok);
   assign push       = cpu_we && !stall;

   always_comb begin
      mem_a  = cpu_a;
      mem_we = 1'b0;
      mem_wd = 32'd0;
      if (drain) begin
         mem_a  = {addr_q[head_q], 2'b00};
         mem_we = 1'b1;
         mem_wd = data_q[head_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PW'(1);
         if (pop)  head_q <= head_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry payload needs no reset; occupancy is tracked by head/count.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         addr_q[tail_q] <= cpu_a[31:2];
         data_q[tail_q] <= cpu_wd;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a word memory model answers the memory port and a scoreboard checks drained stores.
// Expectations for the load-hazard scenario follow whether STORE_BUFFER_FWD_EN is defined.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_a;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_wd;
   logic [31:0] cpu_rd;
   logic        stall;
   logic [31:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready;
   logic [2:0]  count;
   logic        empty;

   logic [31:0] mem_model [256];
   logic [63:0] exp_q [$];
   logic [63:0] exp_w;
   int          tests = 0;
   int          fails = 0;

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall), .mem_a(mem_a), .mem_we(mem_we),
      .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem_model[mem_a[9:2]];

   // Memory side: every completed write is checked against program order and committed to the model.
   always @(negedge clk) begin
      if (!reset && mem_we && mem_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write got addr=%h data=%h, required no write", mem_a, mem_wd);
         end else begin
            exp_w = exp_q.pop_front();
            if ({mem_a, mem_wd} !== exp_w) begin
               fails++;
               $display("FAIL write_order got addr=%h data=%h, required addr=%h data=%h",
                        mem_a, mem_wd, exp_w[63:32], exp_w[31:0]);
            end
         end
         mem_model[mem_a[9:2]] = mem_wd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      cpu_we = 1'b1; cpu_re = 1'b0; cpu_a = a; cpu_wd = d;
      @(negedge clk);
      while (stall && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (stall) begin
         tests++; fails++;
         $display("FAIL store_timeout addr=%h got stall=1, required 0", a);
      end else begin
         exp_q.push_back({a, d});
      end
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d req=0", count); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b req=1", empty); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got=%b req=0", mem_we); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b req=0", stall); end
      tests++; if (cpu_rd !== 32'd0) begin fails++; $display("FAIL reset_cpu_rd got=%h req=0", cpu_rd); end
      tick();
   endtask

   task automatic test_drain_order();
      mem_ready = 1'b1;
      cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'd5;
      @(negedge clk);
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL empty_store_no_drain got=%b req=0", mem_we); end
      exp_q.push_back({32'h10, 32'd5});
      tick();
      cpu_a = 32'h14; cpu_wd = 32'd7;
      @(negedge clk);
      tests++; if (mem_a !== 32'h10) begin fails++; $display("FAIL drain_first_addr got=%h req=10", mem_a); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL drain_store_stall got=%b req=0", stall); end
      exp_q.push_back({32'h14, 32'd7});
      tick();
      cpu_we = 1'b0;
      @(negedge clk);
      tests++; if (mem_a !== 32'h14 || mem_wd !== 32'd7) begin fails++; $display("FAIL drain_second got=%h/%h req=14/7", mem_a, mem_wd); end
      tests++; if (count !== 3'd1) begin fails++; $display("FAIL drain_count_mid got=%0d req=1", count); end
      tick();
      @(negedge clk);
      tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL drain_count_end got=%0d/%b req=0/1", count, empty); end
      tick();
   endtask

   task automatic test_full_stall();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
      cpu_we = 1'b1; cpu_a = 32'h110; cpu_wd = 32'd5;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall got=%b req=1", stall); end
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got=%0d req=4", count); end
      tick();
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall_hold got=%b req=1", stall); end
      tick();
      mem_ready = 1'b1;
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_pushpop_stall got=%b req=0", stall); end
      tests++; if (mem_a !== 32'h100) begin fails++; $display("FAIL full_head_addr got=%h req=100", mem_a); end
      exp_q.push_back({32'h110, 32'd5});
      tick();
      cpu_we = 1'b0;
      @(negedge clk);
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_pushpop_count got=%0d req=4", count); end
      repeat (5) tick();
      @(negedge clk);
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL full_drained got=%0d req=0", count); end
      tick();
   endtask

   task automatic test_load_forward();
      mem_model[8] = 32'hdead;
      mem_ready = 1'b0;
      store(32'h20, 32'd9);
      store(32'h20, 32'd11);
      cpu_re = 1'b1; cpu_a = 32'h20;
`ifdef STORE_BUFFER_FWD_EN
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fwd_stall got=%b req=0", stall); end
      tests++; if (cpu_rd !== 32'd11) begin fails++; $display("FAIL fwd_data got=%0d req=11", cpu_rd); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL fwd_mem_we got=%b req=0", mem_we); end
      tick();
      cpu_re = 1'b0; mem_ready = 1'b1;
      repeat (3) tick();
`else
      mem_ready = 1'b1;
      @(negedge clk);
      tests++; if (stall !== 1'b1 || mem_wd !== 32'd9) begin fails++; $display("FAIL hazard_drain1 got=%b/%0d req=1/9", stall, mem_wd); end
      tick();
      @(negedge clk);
      tests++; if (stall !== 1'b1 || mem_wd !== 32'd11) begin fails++; $display("FAIL hazard_drain2 got=%b/%0d req=1/11", stall, mem_wd); end
      tick();
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hazard_release got=%b req=0", stall); end
      tests++; if (cpu_rd !== 32'd11) begin fails++; $display("FAIL hazard_data got=%0d req=11", cpu_rd); end
      tick();
      cpu_re = 1'b0;
      tick();
`endif
      @(negedge clk);
      tests++; if (mem_model[8] !== 32'd11) begin fails++; $display("FAIL fwd_mem_final got=%0d req=11", mem_model[8]); end
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL fwd_count got=%0d req=0", count); end
      tick();
   endtask

   task automatic test_load_wait();
      mem_model[12] = 32'h33;
      mem_ready = 1'b0;
      cpu_re = 1'b1; cpu_a = 32'h30;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_wait_stall got=%b req=1", stall); end
      tick();
      mem_ready = 1'b1;
      @(negedge clk);
      tests++; if (stall !== 1'b0 || cpu_rd !== 32'h33) begin fails++; $display("FAIL load_ready got=%b/%h req=0/33", stall, cpu_rd); end
      tick();
      cpu_re = 1'b0;
      @(negedge clk);
      tests++; if (cpu_rd !== 32'd0) begin fails++; $display("FAIL idle_cpu_rd got=%h req=0", cpu_rd); end
      tick();
   endtask

   task automatic test_load_starve();
      mem_model[16] = 32'h4444;
      mem_ready = 1'b0;
      store(32'h50, 32'h55);
      store(32'h54, 32'h56);
      mem_ready = 1'b1;
      cpu_re = 1'b1; cpu_a = 32'h40;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (count !== 3'd2 || mem_we !== 1'b0 || stall !== 1'b0 || cpu_rd !== 32'h4444) begin
            fails++;
            $display("FAIL starve_cycle%0d got cnt=%0d we=%b st=%b rd=%h req 2/0/0/4444", i, count, mem_we, stall, cpu_rd);
         end
         tick();
      end
      cpu_re = 1'b0;
      @(negedge clk);
      tests++; if (mem_we !== 1'b1 || mem_a !== 32'h50) begin fails++; $display("FAIL starve_resume got=%b/%h req=1/50", mem_we, mem_a); end
      repeat (3) tick();
      @(negedge clk);
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL starve_drained got=%0d req=0", count); end
      tick();
   endtask

   task automatic test_wrap();
      mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk);
      tests++; if (count !== 3'd1 || mem_a !== 32'h214 || mem_wd !== 32'hA5) begin
         fails++; $display("FAIL wrap_tail got=%0d/%h/%h req=1/214/a5", count, mem_a, mem_wd);
      end
      tick();
      @(negedge clk);
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_drained got=%0d req=0", count); end
      tick();
   endtask

   task automatic test_reset_mid();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) store(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
      @(negedge clk);
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_count got=%0d req=3", count); end
      tick();
      reset = 1'b1;
      cpu_we = 1'b1; cpu_a = 32'h30C; cpu_wd = 32'hCC;
      tick();
      reset = 1'b0;
      cpu_we = 1'b0;
      exp_q.delete();
      @(negedge clk);
      tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL mid_reset_count got=%0d/%b req=0/1", count, empty); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL mid_reset_mem_we got=%b req=0", mem_we); end
      mem_ready = 1'b1;
      repeat (4) tick();
      tests++; if (mem_model[8'hC0] !== 32'd0) begin fails++; $display("FAIL mid_discarded got=%h req=0", mem_model[8'hC0]); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
      reset = 1'b1; cpu_a = 32'd0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wd = 32'd0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_drain_order();
      test_full_stall();
      test_load_forward();
      test_load_wait();
      test_load_starve();
      test_wrap();
      test_reset_mid();
      repeat (3) tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_writes got=%0d req=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting store buffer between the `mips_cpu` data-memory port and `data_memory`. CPU stores are queued in a FIFO and drained to memory in free cycles. Loads take priority on the memory port and, when forwarding is compiled in, are served from the youngest matching buffered store. Memory with wait states is supported through `mem_ready`; the CPU is held via `stall` (gates the PC `d_flop` enable).

## Interface
- `DEPTH`, 4, number of buffered stores (power of two, ≥2)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears buffer
- `cpu_a`  in  32  CPU data address (byte address, word-aligned)
- `cpu_we`  in  1  CPU store request
- `cpu_re`  in  1  CPU load request (never asserted with `cpu_we`)
- `cpu_wd`  in  32  store data
- `cpu_rd`  out  32  load data to CPU
- `stall`  out  1  CPU must hold PC and request this cycle
- `mem_a`  out  32  memory address
- `mem_we`  out  1  memory write enable
- `mem_wd`  out  32  memory write data
- `mem_rd`  in  32  memory read data (combinational, valid with `mem_ready`)
- `mem_ready`  in  1  memory completes current access at this edge
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `empty`  out  1  `count == 0`

## Operation
- Storage: DEPTH entries {addr[31:2], data[31:0]}, head/tail pointers wrap modulo DEPTH, separate count register.
- Port arbitration, per cycle (combinational):
  - Load phase (`cpu_re`, not blocked by hazard): `mem_a = cpu_a`, `mem_we = 0`. No drain.
  - Otherwise, buffer non-empty: drain head, `mem_a = {head.addr,2'b00}`, `mem_wd = head.data`, `mem_we = 1`.
  - Otherwise: `mem_a = cpu_a`, `mem_we = 0`, `mem_wd = 0`.
- Pop: drain active and `mem_ready`.
- Push: `cpu_we` and not `stall`. Push and pop on same edge allowed; count unchanged.
- `stall` = (`cpu_we` and count==DEPTH and not pop) or (`cpu_re` and load not satisfiable this cycle).
- Load satisfiable: forwarded hit (see Configuration), or no hazard and `mem_ready`.
- `cpu_rd`: forwarded data on hit, else `mem_rd`; 0 when `cpu_re` low.
- Address match on word address `cpu_a[31:2]` only; duplicates to the same word are not coalesced (both entries drained in order).
- Stores reach memory in program order.

## Timing
- Reset: count=0, empty=1, head=tail=0; outputs after reset: `mem_we=0`, `stall` only from load path, `cpu_rd=0` with no load.
- Store latency: earliest memory write one cycle after push (entry visible at head next cycle); CPU never stalls on a store unless full and memory not ready.
- Load latency: zero cycles on forward hit or ready memory; one stall cycle per `mem_ready=0` cycle.
- Full + store + drain completing: no stall, push/pop same edge.
- Empty + store: no drain that cycle; write issued next cycle.
- Wrap-around: pointers wrap DEPTH-1 → 0 without bubble.
- Reset mid-operation: buffered stores discarded (not written); reset overrides push/pop in same cycle.
- Back-to-back loads starve draining; buffer drains only in non-load cycles.

## Configuration
- `STORE_BUFFER_FWD_EN` defined: load whose word address matches any entry is satisfied from the youngest matching entry in the same cycle, no memory access needed, no stall.
- Undefined: such a match is a hazard; `stall=1`, the port drains the head instead of loading; load proceeds once no matching entry remains. No forwarding mux built.

## Test plan
- Reset with 3 entries queued → count=0, empty=1, `mem_we=0`, no pending stores written.
- Stores 0x10=5, 0x14=7, `mem_ready=1`, idle cycles → memory writes 0x10=5 then 0x14=7 in consecutive cycles, count returns 0.
- `mem_ready=0`, 5 stores with DEPTH=4 → 5th store `stall=1`, count=4; raise `mem_ready` → push/pop same edge, stall drops, all 5 written in order.
- With FWD_EN: store 0x20=9, store 0x20=11, load 0x20 → `cpu_rd=11`, `stall=0`; memory later holds 11.
- Without FWD_EN: same sequence → `stall=1` for 2 drain cycles, then `cpu_rd=11` from memory.
- Continuous loads to 0x40 with 2 queued stores → count stays 2 until first non-load cycle; pointer wrap after 6 push/pop pairs produces correct order.
